// File: rtl/mod_n_counter_ctrl.sv
// mod_n_counter_ctrl: configurable modulo-N counter with one-shot/continuous modes and wrap counting
module mod_n_counter_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_modulus,
  input  logic             cfg_oneshot,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [7:0]       wraps,
  output logic             cfg_err
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] n, n_d, count_d;
  logic [7:0] wraps_d;
  logic mode, mode_d, err_d, cfg_acc, cfg_ok, last;
  assign cfg_ready = state != RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign cfg_acc = cfg_valid && cfg_ready;
  assign cfg_ok = cfg_modulus >= WIDTH'(2);
  assign last = count == n - WIDTH'(1);
  assign tc = busy && last;
  always_comb begin
    state_d = state;
    count_d = count;
    wraps_d = wraps;
    err_d = cfg_err;
    n_d = n;
    mode_d = mode;
    if (cfg_acc) begin
      err_d = !cfg_ok;
      if (cfg_ok) begin
        n_d = cfg_modulus;
        mode_d = cfg_oneshot;
        state_d = ARMED;
        count_d = '0;
      end
    end else if (start && (state == ARMED || state == DONE)) begin
      state_d = RUN;
      count_d = '0;
      wraps_d = '0;
    end else if (state == RUN) begin
      if (stop) begin
        state_d = ARMED;
        count_d = '0;
      end else if (last) begin
        count_d = '0;
        state_d = mode ? DONE : RUN;
        wraps_d = mode ? 8'd1 : (wraps == 8'hff ? wraps : wraps + 8'd1);
      end else begin
        count_d = count + WIDTH'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      count <= '0;
      wraps <= '0;
      cfg_err <= 1'b0;
      n <= '0;
      mode <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      wraps <= wraps_d;
      cfg_err <= err_d;
      n <= n_d;
      mode <= mode_d;
    end
  end
endmodule

// File: tb/tb_mod_n_counter_ctrl.sv
// tb_mod_n_counter_ctrl: directed self-checking bench for mod_n_counter_ctrl
module tb_mod_n_counter_ctrl;
  logic clk = 1'b0;
  logic clr, cfg_valid, cfg_oneshot, cfg_ready, start, stop, tc, busy, done, cfg_err;
  logic [2:0] cfg_modulus, count;
  logic [7:0] wraps;
  int errors = 0;
  int checks = 0;
  int bad, maxc, expw;
  mod_n_counter_ctrl #(.WIDTH(3)) dut (
    .clk(clk), .clr(clr), .cfg_valid(cfg_valid), .cfg_modulus(cfg_modulus),
    .cfg_oneshot(cfg_oneshot), .cfg_ready(cfg_ready), .start(start), .stop(stop),
    .count(count), .tc(tc), .busy(busy), .done(done), .wraps(wraps), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cfg(input logic [2:0] m, input logic os);
    cfg_valid = 1'b1;
    cfg_modulus = m;
    cfg_oneshot = os;
    step();
    cfg_valid = 1'b0;
  endtask
  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, int'(cfg_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_tc"}, int'(tc), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_wraps"}, int'(wraps), 0);
    chk({tag, "_err"}, int'(cfg_err), 0);
  endtask
  initial begin
    clr = 1'b1; cfg_valid = 1'b0; cfg_modulus = '0; cfg_oneshot = 1'b0; start = 1'b0; stop = 1'b0;
    step();
    step();
    clr = 1'b0;
    chk_reset("reset");
    go();
    chk("idle_start_ignored", int'(busy), 0);
    cfg(3'd3, 1'b0);
    chk("armed_busy", int'(busy), 0);
    chk("armed_ready", int'(cfg_ready), 1);
    chk("armed_count", int'(count), 0);
    go();
    chk("run_ready", int'(cfg_ready), 0);
    for (int i = 0; i < 9; i++) begin
      chk("n3_count", int'(count), i % 3);
      chk("n3_tc", int'(tc), (i % 3 == 2) ? 1 : 0);
      chk("n3_wraps", int'(wraps), i / 3);
      step();
    end
    chk("n3_wraps_end", int'(wraps), 3);
    chk("n3_busy", int'(busy), 1);
    step();
    step();
    chk("pre_stop_count", int'(count), 2);
    chk("pre_stop_tc", int'(tc), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_count", int'(count), 0);
    chk("stop_wraps", int'(wraps), 3);
    chk("stop_done", int'(done), 0);
    chk("stop_tc", int'(tc), 0);
    cfg(3'd5, 1'b1);
    for (int r = 0; r < 2; r++) begin
      go();
      chk("os_wraps_start", int'(wraps), 0);
      for (int i = 0; i < 5; i++) begin
        chk("os_count", int'(count), i);
        chk("os_tc", int'(tc), (i == 4) ? 1 : 0);
        chk("os_busy", int'(busy), 1);
        step();
      end
      chk("os_done", int'(done), 1);
      chk("os_busy_end", int'(busy), 0);
      chk("os_count_end", int'(count), 0);
      chk("os_wraps_end", int'(wraps), 1);
      chk("os_tc_end", int'(tc), 0);
      step();
      chk("os_done_hold", int'(done), 1);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    cfg(3'd1, 1'b0);
    chk("n1_err", int'(cfg_err), 1);
    chk("n1_ready", int'(cfg_ready), 1);
    go();
    chk("n1_still_idle", int'(busy), 0);
    cfg(3'd0, 1'b0);
    chk("n0_err", int'(cfg_err), 1);
    cfg(3'd4, 1'b0);
    chk("n4_err_clear", int'(cfg_err), 0);
    go();
    chk("n4_run", int'(busy), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    cfg_valid = 1'b1; cfg_modulus = 3'd3; cfg_oneshot = 1'b0; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    chk("cfg_beats_start", int'(busy), 0);
    go();
    step();
    chk("pre_clr_count", int'(count), 1);
    clr = 1'b1; start = 1'b1; stop = 1'b1; cfg_valid = 1'b1;
    step();
    clr = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    chk_reset("clr_mid_run");
    go();
    chk("clr_start_ignored", int'(busy), 0);
    cfg(3'd7, 1'b0);
    go();
    bad = 0;
    maxc = 0;
    for (int i = 0; i < 300 * 7; i++) begin
      expw = (i / 7 > 255) ? 255 : i / 7;
      if (int'(count) > maxc) maxc = int'(count);
      if (int'(count) != i % 7 || int'(wraps) != expw || int'(tc) != ((i % 7 == 6) ? 1 : 0)) bad++;
      step();
    end
    chk("n7_trace_errors", bad, 0);
    chk("n7_max_count", maxc, 6);
    chk("n7_wraps_sat", int'(wraps), 255);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_reset("final_clr");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
